// File: rtl/codificador_param_if.sv
// Bundle of the coder's request/data inputs and its parallel/serial code outputs.
// The master side drives the request; the slave side is the coder itself.
interface codificador_param_if #(
  parameter int W = 4
);
  logic         ready;
  logic [W-1:0] din;
  logic [1:0]   mode;
  logic [W-1:0] dout;
  logic         valid;
  logic         busy;
  logic         sout;
  logic         sout_valid;
  logic         overrun;

  modport master (
    output ready, din, mode,
    input  dout, valid, busy, sout, sout_valid, overrun
  );

  modport slave (
    input  ready, din, mode,
    output dout, valid, busy, sout, sout_valid, overrun
  );
endinterface

// File: rtl/codificador_param.sv
// Captures a W-bit word on a rising edge of ready, encodes it (binary, Gray,
// Excess-3 or ones' complement), presents it in parallel and shifts it out MSB first.
module codificador_param #(
  parameter int W    = 4,
  parameter int CNTW = 3
) (
  input  logic clk,
  input  logic reset,
  codificador_param_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    SHIFT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ready_q;
  logic [W-1:0]    din_q, din_d;
  logic [1:0]      mode_q, mode_d;
  logic [W-1:0]    dout_q, dout_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            rise;
  logic [W-1:0]    gray;
  logic [W-1:0]    code;

  assign rise = bus.ready & ~ready_q;

  // Gray code: each bit is the XOR of itself with its more significant neighbour.
  generate
    for (genvar gi = 0; gi < W - 1; gi++) begin : g_gray
      assign gray[gi] = din_q[gi] ^ din_q[gi+1];
    end
  endgenerate
  assign gray[W-1] = din_q[W-1];

  always_comb begin
    code = din_q;
    unique case (mode_q)
      2'd0:    code = din_q;
      2'd1:    code = gray;
      2'd2:    code = din_q + W'(3);
      default: code = ~din_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    mode_d    = mode_q;
    dout_d    = dout_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    // Any edge outside IDLE, including the cycle SHIFT hands back, is an overrun.
    overrun_d = overrun_q | (rise & (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          din_d   = bus.din;
          mode_d  = bus.mode;
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        dout_d  = code;
        shreg_d = code;
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = {shreg_q[W-2:0], 1'b0};
        cnt_d   = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(W - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ready_q resets high so a ready held across reset release is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      din_q     <= '0;
      mode_q    <= '0;
      dout_q    <= '0;
      shreg_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= bus.ready;
      din_q     <= din_d;
      mode_q    <= mode_d;
      dout_q    <= dout_d;
      shreg_q   <= shreg_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.sout       = (state_q == SHIFT) & shreg_q[W-1];
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_codificador_param.sv
// Directed and exhaustive check of codificador_param at W=4; expected words and
// serial bits are queued at capture and compared as the coder emits them.
module tb_codificador_param;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [W-1:0] exp_words[$];
  logic         exp_bits[$];

  codificador_param_if #(.W(W)) bus();

  codificador_param #(.W(W), .CNTW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_enc(input logic [W-1:0] d, input logic [1:0] m);
    case (m)
      2'd0:    ref_enc = d;
      2'd1:    ref_enc = d ^ (d >> 1);
      2'd2:    ref_enc = W'(d + 3);
      default: ref_enc = ~d;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] w);
    exp_words.push_back(w);
    for (int i = W - 1; i >= 0; i--) exp_bits.push_back(w[i]);
  endtask

  // Drives one capture edge; returns just after the capturing clock edge.
  task automatic start(input logic [W-1:0] d, input logic [1:0] m, input logic [W-1:0] e);
    bus.din   = d;
    bus.mode  = m;
    bus.ready = 1'b1;
    push_exp(e);
    tick();
    bus.ready = 1'b0;
  endtask

  task automatic finish_run(output int bb, output int vv, output int sv);
    int n;
    n = 0; bb = 0; vv = 0; sv = 0;
    while (bus.busy && n < 20) begin
      bb++;
      vv += int'(bus.valid);
      sv += int'(bus.sout_valid);
      tick();
      n++;
    end
  endtask

  // Scoreboard side: pop the expected word on valid and a bit per serial cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.valid) begin
        if (exp_words.size() == 0) check("valid_unexpected", 32'(exp_words.size()), 1);
        else check("dout_word", bus.dout, exp_words.pop_front());
      end
      if (bus.sout_valid) begin
        if (exp_bits.size() == 0) check("sout_unexpected", 32'(exp_bits.size()), 1);
        else check("sout_bit", bus.sout, exp_bits.pop_front());
      end
    end
  end

  initial begin
    int bb, vv, sv;
    bus.ready = 1'b1;
    bus.din   = '0;
    bus.mode  = '0;

    // Reset with ready held high: release must not capture.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("rst_busy", bus.busy, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_sout_valid", bus.sout_valid, 0);
    bus.ready = 1'b0;
    tick();

    // Gray 0101 -> 0111, timing of busy/valid/serial window.
    start(4'b0101, 2'd1, 4'b0111);
    finish_run(bb, vv, sv);
    check("t2_busy_cycles", bb, 5);
    check("t2_valid_cycles", vv, 1);
    check("t2_sout_cycles", sv, 4);
    check("t2_dout", bus.dout, 4'b0111);
    check("t2_valid_low", bus.valid, 0);

    // Excess-3 wrap and zero.
    start(4'b1101, 2'd2, 4'b0000);
    finish_run(bb, vv, sv);
    check("t3_dout_wrap", bus.dout, 4'b0000);
    start(4'b0000, 2'd2, 4'b0011);
    finish_run(bb, vv, sv);
    check("t3_dout_zero", bus.dout, 4'b0011);

    // Ones' complement, then binary with serial 1,0,0,1; edge on the return-to-IDLE cycle.
    start(4'b0011, 2'd3, 4'b1100);
    finish_run(bb, vv, sv);
    check("t4_dout_ones", bus.dout, 4'b1100);
    check("t4_overrun_clear", bus.overrun, 0);
    start(4'b1001, 2'd0, 4'b1001);
    tick(); tick(); tick(); tick();
    bus.ready = 1'b1;
    tick();
    check("t5_return_edge_busy", bus.busy, 0);
    check("t5_return_edge_overrun", bus.overrun, 1);
    bb = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bb += int'(bus.busy);
    end
    check("t5_held_high_no_capture", bb, 0);
    check("t5_dout_kept", bus.dout, 4'b1001);
    bus.ready = 1'b0;
    tick();

    // Edge two cycles into SHIFT with changed inputs: word in flight unaffected.
    start(4'b0110, 2'd2, 4'b1001);
    tick(); tick();
    bus.ready = 1'b1;
    bus.din   = 4'hF;
    bus.mode  = 2'd3;
    tick();
    bus.ready = 1'b0;
    finish_run(bb, vv, sv);
    check("t5_dout_in_flight", bus.dout, 4'b1001);
    check("t5_overrun_set", bus.overrun, 1);
    start(4'b1100, 2'd3, 4'b0011);
    finish_run(bb, vv, sv);
    check("t5_dout_after", bus.dout, 4'b0011);
    check("t5_overrun_sticky", bus.overrun, 1);

    // Reset in the second SHIFT cycle aborts the word.
    start(4'b1010, 2'd1, 4'b1111);
    tick(); tick();
    reset = 1'b1;
    tick();
    exp_bits.delete();
    check("t6_busy", bus.busy, 0);
    check("t6_sout_valid", bus.sout_valid, 0);
    check("t6_dout", bus.dout, 0);
    check("t6_overrun", bus.overrun, 0);
    reset = 1'b0;
    tick();
    start(4'b0111, 2'd0, 4'b0111);
    finish_run(bb, vv, sv);
    check("t6_fresh_dout", bus.dout, 4'b0111);
    check("t6_fresh_busy_cycles", bb, 5);

    // All words in all modes against the reference model.
    for (int m = 0; m < 4; m++) begin
      for (int d = 0; d < 16; d++) begin
        start(W'(d), 2'(m), ref_enc(W'(d), 2'(m)));
        finish_run(bb, vv, sv);
        check("sweep_dout", bus.dout, ref_enc(W'(d), 2'(m)));
        check("sweep_busy_cycles", bb, 5);
      end
    end

    tick();
    check("words_drained", 32'(exp_words.size()), 0);
    check("bits_drained", 32'(exp_bits.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
